// File: rtl/pi_lock_servo.sv
// Proportional-integral lock servo for the OPO cavity loop.
// Takes the filtered error stream, applies programmable P and I gains with a
// saturating integrator and anti-windup, and drives a clamped actuator word.
// Four-stage pipeline, one sample per clock, four clocks of latency.
module pi_lock_servo #(
    parameter int word_width = 16,
    parameter int gain_width = 16,
    parameter int gain_frac  = 8,
    parameter int int_width  = 40
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable_i,
    input  logic                         hold_i,
    input  logic                         integ_clear_i,
    input  logic signed [gain_width-1:0] kp_i,
    input  logic signed [gain_width-1:0] ki_i,
    input  logic signed [word_width-1:0] setpoint_i,
    input  logic signed [word_width-1:0] out_min_i,
    input  logic signed [word_width-1:0] out_max_i,
    input  logic signed [word_width-1:0] err_in_i,
    input  logic                         err_valid_i,
    output logic signed [word_width-1:0] ctrl_out_o,
    output logic                         ctrl_valid_o,
    output logic                         saturated_o
);

    localparam int EW = word_width + 1;
    localparam int PW = gain_width + word_width + 1;
    localparam int SW = int_width + 2;

    localparam logic signed [int_width:0] IntMaxW = {2'b00, {(int_width-1){1'b1}}};
    localparam logic signed [int_width:0] IntMinW = -IntMaxW;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t state_q, state_d;
    logic   accept;

    logic signed [EW-1:0]        e_d, e1_q;
    logic                        v1_q;
    logic signed [PW-1:0]        kp_ext, ki_ext, e_ext;
    logic signed [PW-1:0]        p_d, i_d, p2_q, i2_q;
    logic                        v2_q;
    logic signed [int_width:0]   integ_wide, i_wide;
    logic signed [int_width-1:0] integ_d, integ_q, integ_shift;
    logic signed [PW-1:0]        p_shift;
    logic signed [SW-1:0]        sum_d, sum3_q, clamp3, clamp4;
    logic                        v3_q;
    logic                        sat_hi, sat_lo, i_pos, i_neg, windup_block;
    logic signed [word_width-1:0] ctrl_d, ctrl_out_q;
    logic                        sat_d, saturated_q, ctrl_valid_q;

    // Output clamp: upper limit applied first, lower limit last so out_min wins.
    function automatic logic signed [SW-1:0] clampSum(
        input logic signed [SW-1:0]         s,
        input logic signed [word_width-1:0] lo,
        input logic signed [word_width-1:0] hi
    );
        logic signed [SW-1:0] lo_w, hi_w, r;
        lo_w = {{(SW-word_width){lo[word_width-1]}}, lo};
        hi_w = {{(SW-word_width){hi[word_width-1]}}, hi};
        r = s;
        if (r > hi_w) r = hi_w;
        if (r < lo_w) r = lo_w;
        return r;
    endfunction

    // Mode selection and sample acceptance; only a running, unheld servo takes samples.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE:    if (enable_i) state_d = hold_i ? HOLD : RUN;
            RUN:     if (!enable_i) state_d = IDLE; else if (hold_i) state_d = HOLD;
            HOLD:    if (!enable_i) state_d = IDLE; else if (!hold_i) state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && enable_i && !hold_i && err_valid_i) accept = 1'b1;
    end

    // Mode register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath arithmetic for all stages: error, gain products, integrator, sum and clamps.
    always_comb begin
        e_d    = {setpoint_i[word_width-1], setpoint_i} - {err_in_i[word_width-1], err_in_i};

        kp_ext = {{EW{kp_i[gain_width-1]}}, kp_i};
        ki_ext = {{EW{ki_i[gain_width-1]}}, ki_i};
        e_ext  = {{gain_width{e1_q[EW-1]}}, e1_q};
        p_d    = kp_ext * e_ext;
        i_d    = ki_ext * e_ext;

        i_wide     = {{(int_width+1-PW){i2_q[PW-1]}}, i2_q};
        integ_wide = {integ_q[int_width-1], integ_q} + i_wide;
        if (integ_wide > IntMaxW)      integ_d = IntMaxW[int_width-1:0];
        else if (integ_wide < IntMinW) integ_d = IntMinW[int_width-1:0];
        else                           integ_d = integ_wide[int_width-1:0];

        p_shift     = p2_q >>> gain_frac;
        integ_shift = integ_d >>> gain_frac;
        sum_d       = {{(SW-PW){p_shift[PW-1]}}, p_shift}
                    + {{2{integ_shift[int_width-1]}}, integ_shift};

        clamp3       = clampSum(sum_d, out_min_i, out_max_i);
        sat_hi       = clamp3 < sum_d;
        sat_lo       = clamp3 > sum_d;
        i_pos        = !i2_q[PW-1] && (i2_q != '0);
        i_neg        = i2_q[PW-1];
        windup_block = (sat_hi && i_pos) || (sat_lo && i_neg);

        clamp4 = clampSum(sum3_q, out_min_i, out_max_i);
        ctrl_d = clamp4[word_width-1:0];
        sat_d  = clamp4 != sum3_q;
    end

    // Stage valids; dropping enable squashes everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            v1_q <= accept;
            v2_q <= v1_q && enable_i;
            v3_q <= v2_q && enable_i;
        end
    end

    // Stage data registers only move when their stage carries a valid sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e1_q   <= '0;
            p2_q   <= '0;
            i2_q   <= '0;
            sum3_q <= '0;
        end else begin
            if (accept) e1_q <= e_d;
            if (v1_q) begin
                p2_q <= p_d;
                i2_q <= i_d;
            end
            if (v2_q) sum3_q <= sum_d;
        end
    end

    // Integrator: clear and idle force zero; otherwise commit unless it would wind up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          integ_q <= '0;
        else if (integ_clear_i || state_q == IDLE)        integ_q <= '0;
        else if (v2_q && enable_i && !windup_block)       integ_q <= integ_d;
    end

    // Output stage: clamp, flag saturation and pulse valid; zeroed while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_out_q   <= '0;
            saturated_q  <= 1'b0;
            ctrl_valid_q <= 1'b0;
        end else if (state_q == IDLE) begin
            ctrl_out_q   <= '0;
            saturated_q  <= 1'b0;
            ctrl_valid_q <= 1'b0;
        end else begin
            ctrl_valid_q <= v3_q && enable_i;
            if (v3_q && enable_i) begin
                ctrl_out_q  <= ctrl_d;
                saturated_q <= sat_d;
            end
        end
    end

    assign ctrl_out_o   = ctrl_out_q;
    assign ctrl_valid_o = ctrl_valid_q;
    assign saturated_o  = saturated_q;

endmodule
